// File: rtl/eth_arp_tx_if.sv
// Trigger and GMII transmit signals of the ARP frame transmitter.
// master = controller side (arp_ctrl), slave = eth_arp_tx itself.
interface eth_arp_tx_if;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;
    logic        tx_done;
    logic        tx_busy;

    modport master (
        output arp_tx_en, arp_tx_type, des_mac, des_ip,
        input  gmii_tx_en, gmii_txd, tx_done, tx_busy
    );

    modport slave (
        input  arp_tx_en, arp_tx_type, des_mac, des_ip,
        output gmii_tx_en, gmii_txd, tx_done, tx_busy
    );
endinterface

// File: rtl/eth_arp_tx.sv
// GMII ARP transmitter: one strobe emits preamble, Ethernet II header, ARP
// payload, zero pad and CRC-32 FCS as 72 back-to-back bytes, then an IFG.
module eth_arp_tx #(
    parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter logic [47:0] DES_MAC    = 48'hff_ff_ff_ff_ff_ff,
    parameter int          IFG_CYCLES = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    eth_arp_tx_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_HEAD = 3'd2;
    localparam logic [2:0] S_ARP  = 3'd3;
    localparam logic [2:0] S_PAD  = 3'd4;
    localparam logic [2:0] S_FCS  = 3'd5;
    localparam logic [2:0] S_IFG  = 3'd6;

    localparam int CNT_MAX = (IFG_CYCLES > 28) ? IFG_CYCLES : 28;
    localparam int CNT_W   = $clog2(CNT_MAX);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_type;
    logic [47:0]      r_des_mac;
    logic [31:0]      r_des_ip;
    logic [31:0]      r_crc;
    logic             r_tx_done;

    logic [111:0]     w_head;
    logic [223:0]     w_arp;
    logic [CNT_W-1:0] w_head_idx;
    logic [CNT_W-1:0] w_arp_idx;
    logic [7:0]       w_head_byte;
    logic [7:0]       w_arp_byte;
    logic [7:0]       w_fcs_byte;
    logic [7:0]       w_byte;
    logic             w_last;
    logic             w_crc_en;
    logic             w_tx_en;

    // Reflected CRC-32 (poly 04C11DB7), one byte per call, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    assign w_head = {(r_type ? r_des_mac : DES_MAC), BOARD_MAC, 16'h0806};
    assign w_arp  = {16'h0001, 16'h0800, 8'h06, 8'h04, (r_type ? 16'h0002 : 16'h0001),
                     BOARD_MAC, BOARD_IP, (r_type ? r_des_mac : 48'h0), r_des_ip};

    // Fields are sent MSB byte first, so index from the top of each vector.
    assign w_head_idx  = CNT_W'(13) - r_cnt;
    assign w_arp_idx   = CNT_W'(27) - r_cnt;
    assign w_head_byte = 8'(w_head >> {w_head_idx, 3'b000});
    assign w_arp_byte  = 8'(w_arp >> {w_arp_idx, 3'b000});
    assign w_fcs_byte  = 8'(~r_crc >> {r_cnt, 3'b000});

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_byte = 8'h00;
        w_last = 1'b0;
        case (r_state)
            S_PRE: begin
                w_byte = (r_cnt == CNT_W'(7)) ? 8'hD5 : 8'h55;
                w_last = (r_cnt == CNT_W'(7));
            end
            S_HEAD: begin
                w_byte = w_head_byte;
                w_last = (r_cnt == CNT_W'(13));
            end
            S_ARP: begin
                w_byte = w_arp_byte;
                w_last = (r_cnt == CNT_W'(27));
            end
            S_PAD:   w_last = (r_cnt == CNT_W'(17));
            S_FCS: begin
                w_byte = w_fcs_byte;
                w_last = (r_cnt == CNT_W'(3));
            end
            S_IFG:   w_last = (r_cnt == CNT_W'(IFG_CYCLES - 1));
            default: w_last = 1'b0;
        endcase
    end

    assign w_crc_en = (r_state == S_HEAD) || (r_state == S_ARP) || (r_state == S_PAD);
    assign w_tx_en  = (r_state != S_IDLE) && (r_state != S_IFG);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_type    <= 1'b0;
            r_des_mac <= '0;
            r_des_ip  <= '0;
            r_crc     <= 32'hFFFF_FFFF;
            r_tx_done <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            if (w_crc_en)
                r_crc <= crc32_byte(r_crc, w_byte);
            if (r_state == S_IDLE) begin
                if (bus.arp_tx_en) begin
                    r_type    <= bus.arp_tx_type;
                    r_des_mac <= bus.des_mac;
                    r_des_ip  <= bus.des_ip;
                    r_crc     <= 32'hFFFF_FFFF;
                    r_state   <= S_PRE;
                    r_cnt     <= '0;
                end
            end else if (w_last) begin
                r_state   <= (r_state == S_IFG) ? S_IDLE : r_state + 3'd1;
                r_cnt     <= '0;
                r_tx_done <= (r_state == S_FCS);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.gmii_tx_en = w_tx_en;
    assign bus.gmii_txd   = w_byte;
    assign bus.tx_done    = r_tx_done;
    assign bus.tx_busy    = (r_state != S_IDLE);
endmodule

// File: tb/tb_eth_arp_tx.sv
// Self-checking bench for eth_arp_tx: table-driven frames, timing corner cases
// and randomized back-to-back frames against a byte-list reference model.
module tb_eth_arp_tx;
    localparam int IFG       = 12;
    localparam int FRAME_LEN = 72;

    logic clk = 1'b0;
    logic rst_n;

    eth_arp_tx_if bus();

    eth_arp_tx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor state
    logic       mon_on = 1'b0;
    logic [7:0] cur_buf [128];
    logic [7:0] last_frame [128];
    int cur_len = 0, cur_start = 0;
    int last_len = 0, last_start = 0, last_end = 0, last_gap = 0, frame_count = 0;
    int done_count = 0, last_done = 0, busy_run = 0, last_busy_len = 0;
    int idle_bad = 0, busy_bad = 0;
    logic prev_en = 1'b0, prev_busy = 1'b0;

    logic [7:0] exp_frame [FRAME_LEN];

    typedef struct {
        logic        typ;
        logic [47:0] mac;
        logic [31:0] ip;
        logic [47:0] exp_da;
        logic [15:0] exp_oper;
        logic [47:0] exp_tha;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Bit-serial reflected CRC-32 model.
    function automatic logic [31:0] crc_model(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ d[b];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB8_8320;
        end
        return c;
    endfunction

    task automatic build_expected(input logic typ, input logic [47:0] mac, input logic [31:0] ip);
        logic [7:0]   q[$];
        logic [479:0] body;
        logic [47:0]  da;
        logic [47:0]  tha;
        logic [15:0]  oper;
        logic [31:0]  crc;
        da   = typ ? mac : 48'hFFFF_FFFF_FFFF;
        tha  = typ ? mac : 48'h0;
        oper = typ ? 16'd2 : 16'd1;
        body = {da, 48'h0011_2233_4455, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, oper,
                48'h0011_2233_4455, 32'hC0A8_010A, tha, ip, 144'h0};
        for (int i = 0; i < 7; i++) q.push_back(8'h55);
        q.push_back(8'hD5);
        for (int i = 0; i < 60; i++) q.push_back(body[479 - 8*i -: 8]);
        crc = 32'hFFFF_FFFF;
        for (int i = 8; i < 68; i++) crc = crc_model(crc, q[i]);
        crc = ~crc;
        for (int i = 0; i < 4; i++) q.push_back(crc[8*i +: 8]);
        for (int i = 0; i < FRAME_LEN; i++) exp_frame[i] = q[i];
    endtask

    function automatic logic [63:0] field(input int off, input int n);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = {v[55:0], last_frame[off + i]};
        return v;
    endfunction

    function automatic logic [31:0] residue();
        logic [31:0] c;
        logic [31:0] r;
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < FRAME_LEN; i++) c = crc_model(c, last_frame[i]);
        r = {<<{c}};
        return r;
    endfunction

    function automatic int frame_diff();
        int n;
        n = 0;
        for (int i = 0; i < FRAME_LEN; i++)
            if (last_frame[i] !== exp_frame[i]) n++;
        return n;
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (bus.gmii_tx_en === 1'b1) begin
                    if (!prev_en) begin
                        cur_len   = 0;
                        cur_start = cyc;
                        last_gap  = cyc - last_end;
                    end
                    if (cur_len < 128) cur_buf[cur_len] = bus.gmii_txd;
                    cur_len++;
                end else begin
                    if (bus.gmii_txd !== 8'h00) idle_bad++;
                    if (prev_en) begin
                        last_frame  = cur_buf;
                        last_len    = cur_len;
                        last_start  = cur_start;
                        last_end    = cyc;
                        frame_count++;
                    end
                end
                if (bus.tx_done === 1'b1) begin
                    done_count++;
                    last_done = cyc;
                end
                if (bus.tx_busy === 1'b1) busy_run++;
                else begin
                    if (prev_busy) last_busy_len = busy_run;
                    busy_run = 0;
                end
                if ((bus.gmii_tx_en === 1'b1 || bus.tx_done === 1'b1) && bus.tx_busy !== 1'b1)
                    busy_bad++;
                prev_en   = (bus.gmii_tx_en === 1'b1);
                prev_busy = (bus.tx_busy === 1'b1);
            end
        end
    end

    task automatic strobe(input logic typ, input logic [47:0] mac, input logic [31:0] ip,
                          output int s_cyc);
        bus.arp_tx_type = typ;
        bus.des_mac     = mac;
        bus.des_ip      = ip;
        bus.arp_tx_en   = 1'b1;
        s_cyc           = cyc;
        tick();
        bus.arp_tx_en   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.tx_busy === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check(name, 64'(bus.tx_busy), 64'd0);
    endtask

    task automatic check_frame(input string tag, input int s, input logic typ,
                               input logic [47:0] mac, input logic [31:0] ip, input int dc0);
        build_expected(typ, mac, ip);
        check({tag, "_len"},       64'(last_len), 64'(FRAME_LEN));
        check({tag, "_start_lat"}, 64'(last_start - s), 64'd1);
        check({tag, "_done_lat"},  64'(last_done - s), 64'(FRAME_LEN + 1));
        check({tag, "_done_cnt"},  64'(done_count - dc0), 64'd1);
        check({tag, "_bytes_bad"}, 64'(frame_diff()), 64'd0);
        check({tag, "_residue"},   64'(residue()), 64'hC704_DD7B);
        check({tag, "_busy_len"},  64'(last_busy_len), 64'(FRAME_LEN + IFG));
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, s1, dc0, fc0;
        logic        r_typ;
        logic [47:0] r_mac;
        logic [31:0] r_ip;

        vecs[0] = '{typ: 1'b0, mac: 48'h0123_4567_89AB, ip: 32'hC0A8_0166,
                    exp_da: 48'hFFFF_FFFF_FFFF, exp_oper: 16'h0001, exp_tha: 48'h0};
        vecs[1] = '{typ: 1'b1, mac: 48'h0A1B_2C3D_4E5F, ip: 32'hC0A8_0102,
                    exp_da: 48'h0A1B_2C3D_4E5F, exp_oper: 16'h0002, exp_tha: 48'h0A1B_2C3D_4E5F};
        vecs[2] = '{typ: 1'b1, mac: 48'h0000_0000_0001, ip: 32'h0000_0000,
                    exp_da: 48'h0000_0000_0001, exp_oper: 16'h0002, exp_tha: 48'h0000_0000_0001};
        vecs[3] = '{typ: 1'b0, mac: 48'hDEAD_BEEF_0001, ip: 32'hFFFF_FFFF,
                    exp_da: 48'hFFFF_FFFF_FFFF, exp_oper: 16'h0001, exp_tha: 48'h0};

        rst_n           = 1'b0;
        bus.arp_tx_en   = 1'b0;
        bus.arp_tx_type = 1'b0;
        bus.des_mac     = '0;
        bus.des_ip      = '0;
        repeat (3) tick();
        check("rst_tx_en", 64'(bus.gmii_tx_en), 64'd0);
        check("rst_txd",   64'(bus.gmii_txd),   64'd0);
        check("rst_done",  64'(bus.tx_done),    64'd0);
        check("rst_busy",  64'(bus.tx_busy),    64'd0);
        rst_n = 1'b1;
        tick();
        mon_on = 1'b1;
        check("idle_tx_en", 64'(bus.gmii_tx_en), 64'd0);
        check("idle_busy",  64'(bus.tx_busy),    64'd0);

        // Table-driven frames
        for (int v = 0; v < 4; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            dc0 = done_count;
            strobe(vecs[v].typ, vecs[v].mac, vecs[v].ip, s);
            wait_idle({tag, "_idle"});
            check_frame(tag, s, vecs[v].typ, vecs[v].mac, vecs[v].ip, dc0);
            check({tag, "_preamble"}, field(0, 8),  64'h5555_5555_5555_55D5);
            check({tag, "_da"},       field(8, 6),  64'(vecs[v].exp_da));
            check({tag, "_sa"},       field(14, 6), 64'h0011_2233_4455);
            check({tag, "_hdr"},      field(20, 8), 64'h0806_0001_0800_0604);
            check({tag, "_oper"},     field(28, 2), 64'(vecs[v].exp_oper));
            check({tag, "_sha"},      field(30, 6), 64'h0011_2233_4455);
            check({tag, "_spa"},      field(36, 4), 64'hC0A8_010A);
            check({tag, "_tha"},      field(40, 6), 64'(vecs[v].exp_tha));
            check({tag, "_tpa"},      field(46, 4), 64'(vecs[v].ip));
            check({tag, "_pad"},      field(50, 8) | field(58, 8) | field(66, 2), 64'd0);
        end

        // Inputs changed and strobe re-pulsed at frame byte 20
        dc0 = done_count;
        fc0 = frame_count;
        strobe(1'b0, 48'h1111_2222_3333, 32'h0A00_0001, s);
        while (cyc < s + 21) tick();
        bus.arp_tx_type = 1'b1;
        bus.des_mac     = 48'h9999_8888_7777;
        bus.des_ip      = 32'h0B0B_0B0B;
        bus.arp_tx_en   = 1'b1;
        tick();
        bus.arp_tx_en   = 1'b0;
        wait_idle("mid_idle");
        check_frame("mid", s, 1'b0, 48'h1111_2222_3333, 32'h0A00_0001, dc0);
        repeat (100) tick();
        check("mid_frames", 64'(frame_count - fc0), 64'd1);
        check("mid_dones",  64'(done_count - dc0),  64'd1);

        // Strobe on the IFG->IDLE cycle (ignored), held one more cycle (accepted)
        strobe(1'b0, 48'h0, 32'hC0A8_0101, s1);
        while (cyc < s1 + FRAME_LEN + IFG) tick();
        check("ifg_busy_last", 64'(bus.tx_busy), 64'd1);
        bus.arp_tx_type = 1'b1;
        bus.des_mac     = 48'hA0A1_A2A3_A4A5;
        bus.des_ip      = 32'hC0A8_01FE;
        bus.arp_tx_en   = 1'b1;
        tick();
        check("ifg_idle_return", 64'(bus.tx_busy), 64'd0);
        dc0 = done_count;
        tick();
        bus.arp_tx_en = 1'b0;
        wait_idle("ifg_idle");
        check("ifg_start_to_start", 64'(last_start - s1), 64'(1 + FRAME_LEN + IFG + 1));
        check("ifg_gap",            64'(last_gap), 64'(IFG + 1));
        check_frame("ifg2", s1 + FRAME_LEN + IFG + 1, 1'b1, 48'hA0A1_A2A3_A4A5, 32'hC0A8_01FE, dc0);

        // Reset at frame byte 30
        dc0 = done_count;
        fc0 = frame_count;
        strobe(1'b1, 48'h0202_0303_0404, 32'hC0A8_0133, s);
        while (cyc < s + 31) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_tx_en", 64'(bus.gmii_tx_en), 64'd0);
        check("abort_txd",   64'(bus.gmii_txd),   64'd0);
        check("abort_busy",  64'(bus.tx_busy),    64'd0);
        check("abort_done",  64'(bus.tx_done),    64'd0);
        repeat (100) tick();
        check("abort_no_done", 64'(done_count - dc0),  64'd0);
        check("abort_len",     64'(last_len),          64'd31);
        check("abort_frames",  64'(frame_count - fc0), 64'd1);
        dc0 = done_count;
        strobe(1'b0, 48'h0, 32'hC0A8_0177, s);
        wait_idle("post_abort_idle");
        check_frame("post_abort", s, 1'b0, 48'h0, 32'hC0A8_0177, dc0);

        // Randomized back-to-back frames
        for (int it = 0; it < 100; it++) begin
            r_typ = 1'($urandom_range(0, 1));
            r_mac = {16'($urandom), $urandom};
            r_ip  = $urandom;
            dc0   = done_count;
            strobe(r_typ, r_mac, r_ip, s);
            wait_idle("rnd_idle");
            check_frame("rnd", s, r_typ, r_mac, r_ip, dc0);
            check("rnd_gap_ge_ifg", 64'(last_gap >= IFG), 64'd1);
        end

        check("txd_zero_when_idle", 64'(idle_bad), 64'd0);
        check("busy_envelope",      64'(busy_bad), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
